// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame
// Description : UART transmit framer with an internal FIFO. Sends frames with
//               run-time data length (5..MAX_DATA_BITS), optional odd/even
//               parity, 1 or 2 stop bits, break generation, FIFO flush and
//               level/status outputs. Bit timing comes from tx_baud_pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame #(
    parameter int MAX_DATA_BITS = 9,
    parameter int FIFO_DEPTH    = 16,
    parameter int LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic                     tx_baud_pulse,
    input  logic                     wr_valid,
    input  logic [MAX_DATA_BITS-1:0] wr_data,
    input  logic                     cfg_tx_en,
    input  logic [3:0]               cfg_data_bits,
    input  logic                     cfg_parity_en,
    input  logic                     cfg_parity_odd0_even1,
    input  logic                     cfg_stop2,
    input  logic                     cfg_break,
    input  logic                     fifo_flush,
    output logic                     UART_TX,
    output logic                     tx_ready,
    output logic                     tx_empty,
    output logic                     tx_busy,
    output logic [LVL_W-1:0]         fifo_level,
    output logic                     tx_done,
    output logic                     tx_overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5,
        S_BREAK  = 3'd6
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;

    // FIFO storage and bookkeeping
    logic [MAX_DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [LVL_W-1:0]         r_level;

    // Per-frame latched settings and shifter
    logic [MAX_DATA_BITS-1:0] r_shift;
    logic [3:0]               r_nbits;
    logic [3:0]               r_bit_cnt;
    logic                     r_par_en;
    logic                     r_par_bit;
    logic                     r_stop2;
    logic                     r_in_break;

    // Registered outputs
    logic                     r_tx;
    logic                     r_done;
    logic                     r_ovf;

    logic                     w_fifo_empty;
    logic                     w_fifo_full;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_ovf;
    logic                     w_line;
    logic                     w_frame_end;
    logic                     w_break_entry;
    logic [3:0]               w_nbits_cfg;
    logic [MAX_DATA_BITS-1:0] w_mask;
    logic [MAX_DATA_BITS-1:0] w_head;
    logic                     w_par_xor;

    assign w_fifo_empty = (r_level == '0);
    assign w_fifo_full  = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_head       = r_mem[r_rd_ptr];

    // A write that coincides with a pop always finds room; a flush swallows the write silently
    assign w_push = wr_valid && !fifo_flush && (!w_fifo_full || w_pop);
    assign w_ovf  = wr_valid && !fifo_flush && w_fifo_full && !w_pop;

    assign w_break_entry = (r_state == S_IDLE) && tx_baud_pulse && cfg_break;

    // Clamp the requested data length into the supported 5..MAX_DATA_BITS window
    always_comb begin
        if (cfg_data_bits < 4'd5) begin
            w_nbits_cfg = 4'd5;
        end else if (cfg_data_bits > 4'(MAX_DATA_BITS)) begin
            w_nbits_cfg = 4'(MAX_DATA_BITS);
        end else begin
            w_nbits_cfg = cfg_data_bits;
        end
    end

    // Parity covers only the active data bits of the head word
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            w_mask[i] = (i < int'(w_nbits_cfg));
        end
        w_par_xor = ^(w_head & w_mask);
    end

    // Next-state, pop strobe, line level and end-of-frame decode
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_line      = 1'b1;
        w_frame_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_line = 1'b1;
                if (tx_baud_pulse) begin
                    if (cfg_break) begin
                        w_state_nxt = S_BREAK;
                    end else if (!w_fifo_empty && cfg_tx_en) begin
                        w_state_nxt = S_START;
                        w_pop       = 1'b1;
                    end
                end
            end
            S_START: begin
                w_line = 1'b0;
                if (tx_baud_pulse) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_line = r_shift[0];
                if (tx_baud_pulse && (r_bit_cnt == (r_nbits - 4'd1))) begin
                    w_state_nxt = r_par_en ? S_PARITY : S_STOP1;
                end
            end
            S_PARITY: begin
                w_line = r_par_bit;
                if (tx_baud_pulse) begin
                    w_state_nxt = S_STOP1;
                end
            end
            S_STOP1: begin
                w_line = 1'b1;
                if (tx_baud_pulse) begin
                    if (r_stop2) begin
                        w_state_nxt = S_STOP2;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_frame_end = !r_in_break;
                    end
                end
            end
            S_STOP2: begin
                w_line = 1'b1;
                if (tx_baud_pulse) begin
                    w_state_nxt = S_IDLE;
                    w_frame_end = !r_in_break;
                end
            end
            S_BREAK: begin
                w_line = 1'b0;
                if (tx_baud_pulse && !cfg_break) begin
                    w_state_nxt = S_STOP1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO storage write port; contents need no reset since the level gates reads
    always_ff @(posedge ACLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers and occupancy; flush clears them without touching the shifter
    always_ff @(posedge ACLK) begin
        if (ARESET || fifo_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Frame datapath: latch word and settings at frame start, shift during DATA
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_shift    <= '0;
            r_nbits    <= 4'd5;
            r_bit_cnt  <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop2    <= 1'b0;
            r_in_break <= 1'b0;
        end else if (w_pop) begin
            r_shift    <= w_head;
            r_nbits    <= w_nbits_cfg;
            r_bit_cnt  <= '0;
            r_par_en   <= cfg_parity_en;
            r_par_bit  <= cfg_parity_odd0_even1 ? w_par_xor : ~w_par_xor;
            r_stop2    <= cfg_stop2;
            r_in_break <= 1'b0;
        end else if (w_break_entry) begin
            // A break always finishes with a single stop period and no done pulse
            r_stop2    <= 1'b0;
            r_in_break <= 1'b1;
        end else if ((r_state == S_DATA) && tx_baud_pulse) begin
            r_shift    <= r_shift >> 1;
            r_bit_cnt  <= r_bit_cnt + 4'd1;
        end
    end

    // Registered line and status pulses
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_tx   <= 1'b1;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_tx   <= w_line;
            r_done <= w_frame_end;
            r_ovf  <= w_ovf;
        end
    end

    assign UART_TX     = r_tx;
    assign tx_done     = r_done;
    assign tx_overflow = r_ovf;
    assign tx_ready    = !w_fifo_full;
    assign tx_empty    = w_fifo_empty && (r_state == S_IDLE);
    assign tx_busy     = (r_state != S_IDLE);
    assign fifo_level  = r_level;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_tx_frame
// Description : Self-checking bench for uart_tx_frame: directed frame table,
//               FIFO/break/flush/reset sequences and randomized frames against
//               a bit-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;

    localparam int DEPTH = 4;
    localparam int LVW   = 3;
    localparam int BAUD  = 8;

    logic            ACLK = 1'b0;
    logic            ARESET;
    logic            tx_baud_pulse;
    logic            wr_valid;
    logic [8:0]      wr_data;
    logic            cfg_tx_en;
    logic [3:0]      cfg_data_bits;
    logic            cfg_parity_en;
    logic            cfg_parity_odd0_even1;
    logic            cfg_stop2;
    logic            cfg_break;
    logic            fifo_flush;
    logic            UART_TX;
    logic            tx_ready;
    logic            tx_empty;
    logic            tx_busy;
    logic [LVW-1:0]  fifo_level;
    logic            tx_done;
    logic            tx_overflow;

    uart_tx_frame #(
        .MAX_DATA_BITS (9),
        .FIFO_DEPTH    (DEPTH),
        .LVL_W         (LVW)
    ) dut (
        .ACLK                  (ACLK),
        .ARESET                (ARESET),
        .tx_baud_pulse         (tx_baud_pulse),
        .wr_valid              (wr_valid),
        .wr_data               (wr_data),
        .cfg_tx_en             (cfg_tx_en),
        .cfg_data_bits         (cfg_data_bits),
        .cfg_parity_en         (cfg_parity_en),
        .cfg_parity_odd0_even1 (cfg_parity_odd0_even1),
        .cfg_stop2             (cfg_stop2),
        .cfg_break             (cfg_break),
        .fifo_flush            (fifo_flush),
        .UART_TX               (UART_TX),
        .tx_ready              (tx_ready),
        .tx_empty              (tx_empty),
        .tx_busy               (tx_busy),
        .fifo_level            (fifo_level),
        .tx_done               (tx_done),
        .tx_overflow           (tx_overflow)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int ovf_cnt  = 0;
    int phase    = 0;
    bit rec_en   = 1'b0;
    bit samp_q[$];
    int done_q[$];

    // Baud strobe generator and line monitor: one line sample mid-bit per period
    initial begin
        tx_baud_pulse = 1'b0;
        forever begin
            @(negedge ACLK);
            if (rec_en && phase == BAUD / 2) samp_q.push_back(UART_TX);
            if (tx_done === 1'b1) begin
                done_cnt++;
                if (rec_en) done_q.push_back(samp_q.size());
            end
            if (tx_overflow === 1'b1) ovf_cnt++;
            phase = (phase == BAUD - 1) ? 0 : phase + 1;
            tx_baud_pulse = (phase == 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
    endtask

    function automatic string bitc(input bit b);
        return b ? "1" : "0";
    endfunction

    function automatic string strip_ones(input string s);
        string r;
        r = s;
        while (r.len() > 0 && r.getc(r.len() - 1) == "1") begin
            if (r.len() == 1) r = "";
            else r = r.substr(0, r.len() - 2);
        end
        return r;
    endfunction

    // Reference model: the serial bit list of one frame from the framing rules
    function automatic string frame_str(input logic [8:0] w, input int db, input bit pen,
                                        input bit peven, input bit s2);
        int    n;
        int    ones;
        string s;
        n    = (db < 5) ? 5 : ((db > 9) ? 9 : db);
        ones = 0;
        s    = "0";
        for (int i = 0; i < n; i++) begin
            s = {s, bitc(w[i])};
            ones += int'(w[i]);
        end
        if (pen) s = {s, bitc(peven ? (ones % 2 == 1) : (ones % 2 == 0))};
        s = {s, "1"};
        if (s2) s = {s, "1"};
        return s;
    endfunction

    // Captured line from first start bit (trailing idle removed) and done offsets
    task automatic get_stream(output string bits, output string dones);
        int fz;
        fz = samp_q.size();
        for (int i = 0; i < samp_q.size(); i++) begin
            if (samp_q[i] == 1'b0) begin fz = i; break; end
        end
        bits = "";
        for (int i = fz; i < samp_q.size(); i++) bits = {bits, bitc(samp_q[i])};
        bits  = strip_ones(bits);
        dones = "";
        foreach (done_q[i]) dones = {dones, $sformatf("%0d,", done_q[i] - fz)};
    endtask

    task automatic start_capture();
        samp_q.delete();
        done_q.delete();
        rec_en = 1'b1;
    endtask

    task automatic set_cfg(input int db, input bit pen, input bit peven, input bit s2);
        @(negedge ACLK);
        cfg_data_bits         = 4'(db);
        cfg_parity_en         = pen;
        cfg_parity_odd0_even1 = peven;
        cfg_stop2             = s2;
    endtask

    task automatic write_word(input logic [8:0] w);
        @(negedge ACLK);
        wr_valid = 1'b1;
        wr_data  = w;
        @(negedge ACLK);
        wr_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int max_cycles, input string name);
        int t;
        t = 0;
        while (done_cnt < target && t < max_cycles) begin
            @(negedge ACLK);
            t++;
        end
        if (done_cnt < target) begin
            n_checks++;
            $display("FAIL %s_timeout: got %0d done pulses required %0d", name, done_cnt, target);
        end
    endtask

    task automatic wait_busy(input int max_cycles, input string name);
        int t;
        t = 0;
        while (tx_busy !== 1'b1 && t < max_cycles) begin
            @(negedge ACLK);
            t++;
        end
        if (tx_busy !== 1'b1) begin
            n_checks++;
            $display("FAIL %s_busy_timeout: got %b required 1", name, tx_busy);
        end
    endtask

    typedef struct {
        logic [8:0]  word;
        int          db;
        bit          pen;
        bit          peven;
        bit          s2;
        logic [12:0] bits;   // transmit order, bit 0 first
        int          len;
    } vec_t;

    vec_t vecs [5];

    initial begin
        string act_s, act_d, exp_s, exp_d;
        int    base, ov0, z, pos, n;
        int    dbr;
        bit    penr, pevr, s2r;
        logic [8:0] words [4];

        vecs[0] = '{9'h0A5,  8, 1'b0, 1'b0, 1'b0, 13'h034A, 10};  // 8N1
        vecs[1] = '{9'h1C5,  7, 1'b1, 1'b1, 1'b1, 13'h078A, 11};  // 7E2
        vecs[2] = '{9'h1F3,  5, 1'b1, 1'b0, 1'b0, 13'h00A6,  8};  // 5O1
        vecs[3] = '{9'h00A,  3, 1'b0, 1'b0, 1'b0, 13'h0054,  7};  // clamps to 5
        vecs[4] = '{9'h155, 15, 1'b1, 1'b1, 1'b1, 13'h1EAA, 13};  // clamps to 9

        ARESET = 1'b1; wr_valid = 1'b0; wr_data = '0; cfg_tx_en = 1'b0;
        cfg_data_bits = 4'd8; cfg_parity_en = 1'b0; cfg_parity_odd0_even1 = 1'b0;
        cfg_stop2 = 1'b0; cfg_break = 1'b0; fifo_flush = 1'b0;
        repeat (3) @(negedge ACLK);
        ARESET = 1'b0;

        chk("rst_line",  32'(UART_TX), 32'd1);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_empty", 32'(tx_empty), 32'd1);
        chk("rst_busy",  32'(tx_busy), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_done",  32'(tx_done), 32'd0);
        chk("rst_ovf",   32'(tx_overflow), 32'd0);

        // Directed frame table
        for (int v = 0; v < 5; v++) begin
            set_cfg(vecs[v].db, vecs[v].pen, vecs[v].peven, vecs[v].s2);
            cfg_tx_en = 1'b1;
            start_capture();
            base = done_cnt;
            write_word(vecs[v].word);
            wait_done(base + 1, 20 * BAUD, $sformatf("vec%0d", v));
            repeat (3 * BAUD) @(negedge ACLK);
            rec_en = 1'b0;
            get_stream(act_s, act_d);
            exp_s = "";
            for (int i = 0; i < vecs[v].len; i++) exp_s = {exp_s, bitc(vecs[v].bits[i])};
            chk_str($sformatf("vec%0d_bits", v), act_s, strip_ones(exp_s));
            chk_str($sformatf("vec%0d_done", v), act_d, $sformatf("%0d,", vecs[v].len));
        end

        // FIFO limits: fill past depth with the transmitter disabled, then drain in order
        cfg_tx_en = 1'b0;
        set_cfg(8, 1'b0, 1'b0, 1'b0);
        ov0 = ovf_cnt;
        for (int i = 0; i < 5; i++) write_word(9'(8'h11 * (i + 1)));
        repeat (2) @(negedge ACLK);
        chk("lim_level", 32'(fifo_level), 32'd4);
        chk("lim_ready", 32'(tx_ready), 32'd0);
        chk("lim_empty", 32'(tx_empty), 32'd0);
        chk("lim_ovf",   32'(ovf_cnt - ov0), 32'd1);
        start_capture();
        base = done_cnt;
        cfg_tx_en = 1'b1;
        wait_done(base + 4, 60 * BAUD, "lim");
        repeat (3 * BAUD) @(negedge ACLK);
        rec_en = 1'b0;
        get_stream(act_s, act_d);
        exp_s = ""; exp_d = ""; pos = 0;
        for (int i = 0; i < 4; i++) begin
            string f;
            f = frame_str(9'(8'h11 * (i + 1)), 8, 1'b0, 1'b0, 1'b0);
            exp_s = {exp_s, f, "1"};
            exp_d = {exp_d, $sformatf("%0d,", pos + f.len())};
            pos += f.len() + 1;
        end
        chk_str("lim_bits", act_s, strip_ones(exp_s));
        chk_str("lim_done", act_d, exp_d);
        chk("lim_empty_end", 32'(tx_empty), 32'd1);
        chk("lim_level_end", 32'(fifo_level), 32'd0);

        // Break requested mid-frame: frame finishes, break held, then stop and next frame
        set_cfg(8, 1'b0, 1'b0, 1'b0);
        cfg_tx_en = 1'b1;
        start_capture();
        base = done_cnt;
        write_word(9'h03C);
        write_word(9'h0C3);
        wait_busy(4 * BAUD, "brk");
        repeat (3 * BAUD) @(negedge ACLK);
        cfg_break = 1'b1;
        wait_done(base + 1, 20 * BAUD, "brk1");
        repeat (6 * BAUD) @(negedge ACLK);
        chk("brk_level", 32'(fifo_level), 32'd1);
        chk("brk_busy",  32'(tx_busy), 32'd1);
        cfg_break = 1'b0;
        wait_done(base + 2, 20 * BAUD, "brk2");
        repeat (3 * BAUD) @(negedge ACLK);
        rec_en = 1'b0;
        get_stream(act_s, act_d);
        begin
            string f1, f2;
            f1 = frame_str(9'h03C, 8, 1'b0, 1'b0, 1'b0);
            f2 = frame_str(9'h0C3, 8, 1'b0, 1'b0, 1'b0);
            z = 0;
            for (int i = f1.len() + 1; i < act_s.len(); i++) begin
                if (act_s.getc(i) != "0") break;
                z++;
            end
            chk("brk_len_ok", 32'((z >= 5) && (z <= 7)), 32'd1);
            exp_s = {f1, "1"};
            for (int i = 0; i < z; i++) exp_s = {exp_s, "0"};
            exp_s = {exp_s, "11", f2};
            chk_str("brk_bits", act_s, strip_ones(exp_s));
            chk_str("brk_done", act_d, $sformatf("%0d,%0d,", f1.len(),
                    f1.len() + 1 + z + 2 + f2.len()));
        end

        // Flush during the first frame's data bits, with a write in the same cycle
        cfg_tx_en = 1'b0;
        set_cfg(8, 1'b0, 1'b0, 1'b0);
        words[0] = 9'h081; words[1] = 9'h042; words[2] = 9'h024;
        for (int i = 0; i < 3; i++) write_word(words[i]);
        start_capture();
        base = done_cnt;
        ov0 = ovf_cnt;
        cfg_tx_en = 1'b1;
        wait_busy(4 * BAUD, "fl");
        repeat (3 * BAUD) @(negedge ACLK);
        fifo_flush = 1'b1; wr_valid = 1'b1; wr_data = 9'h099;
        @(negedge ACLK);
        fifo_flush = 1'b0; wr_valid = 1'b0;
        @(negedge ACLK);
        chk("fl_level", 32'(fifo_level), 32'd0);
        chk("fl_ovf",   32'(ovf_cnt - ov0), 32'd0);
        chk("fl_busy",  32'(tx_busy), 32'd1);
        wait_done(base + 1, 20 * BAUD, "fl");
        repeat (4 * BAUD) @(negedge ACLK);
        rec_en = 1'b0;
        get_stream(act_s, act_d);
        exp_s = frame_str(words[0], 8, 1'b0, 1'b0, 1'b0);
        chk_str("fl_bits", act_s, strip_ones(exp_s));
        chk_str("fl_done", act_d, $sformatf("%0d,", exp_s.len()));
        chk("fl_empty", 32'(tx_empty), 32'd1);

        // Randomized frames against the reference model
        for (int it = 0; it < 6; it++) begin
            dbr  = $urandom_range(0, 15);
            penr = 1'($urandom_range(0, 1));
            pevr = 1'($urandom_range(0, 1));
            s2r  = 1'($urandom_range(0, 1));
            n    = $urandom_range(1, DEPTH);
            cfg_tx_en = 1'b0;
            set_cfg(dbr, penr, pevr, s2r);
            for (int i = 0; i < n; i++) begin
                words[i] = 9'($urandom_range(0, 511));
                write_word(words[i]);
            end
            chk($sformatf("rnd%0d_level", it), 32'(fifo_level), 32'(n));
            start_capture();
            base = done_cnt;
            cfg_tx_en = 1'b1;
            wait_done(base + n, (n * 15 + 10) * BAUD, $sformatf("rnd%0d", it));
            repeat (3 * BAUD) @(negedge ACLK);
            rec_en = 1'b0;
            get_stream(act_s, act_d);
            exp_s = ""; exp_d = ""; pos = 0;
            for (int i = 0; i < n; i++) begin
                string f;
                f = frame_str(words[i], dbr, penr, pevr, s2r);
                exp_s = {exp_s, f, "1"};
                exp_d = {exp_d, $sformatf("%0d,", pos + f.len())};
                pos += f.len() + 1;
            end
            chk_str($sformatf("rnd%0d_bits", it), act_s, strip_ones(exp_s));
            chk_str($sformatf("rnd%0d_done", it), act_d, exp_d);
        end

        // Reset in the middle of a frame with data low on the line
        set_cfg(8, 1'b0, 1'b0, 1'b0);
        cfg_tx_en = 1'b1;
        write_word(9'h000);
        write_word(9'h000);
        wait_busy(4 * BAUD, "rst");
        repeat (3 * BAUD) @(negedge ACLK);
        chk("mid_line_low", 32'(UART_TX), 32'd0);
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        chk("mid_rst_line",  32'(UART_TX), 32'd1);
        chk("mid_rst_busy",  32'(tx_busy), 32'd0);
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        repeat (3 * BAUD) @(negedge ACLK);
        chk("mid_rst_quiet", 32'(UART_TX), 32'd1);
        cfg_tx_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
